fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rom_req, output, 1, ROM read request.
REQ-004 SHALL have port rom_addr, output, 8, ROM byte address.
REQ-005 SHALL have port rom_ack, input, 1, ROM data valid for the current request this cycle.
REQ-006 SHALL have port rom_data, input, 8, ROM read byte.
REQ-007 SHALL have port opcode, output, 8, fetched opcode to the ucode decoder.
REQ-008 SHALL have port operand, output, 8, immediate byte; 8'h00 for one-byte instructions.
REQ-009 SHALL have port instr_valid, output, 1, opcode/operand hold a complete instruction.
REQ-010 SHALL have port instr_ready, input, 1, downstream accepts the instruction.
REQ-011 SHALL have port jump_en, input, 1, redirect fetch.
REQ-012 SHALL have port jump_target, input, 8, redirect address.
REQ-013 SHALL have port pc, output, 8, address of the next byte to fetch.

Function
REQ-014 SHALL implement states FETCH_OP, FETCH_IMM, VALID.
REQ-015 FETCH_OP/FETCH_IMM: rom_req=1, rom_addr=pc; all other states rom_req=0.
REQ-016 A byte transfers in a cycle with rom_req=1 and rom_ack=1; rom_req may drop without ack (no outstanding transactions).
REQ-017 FETCH_OP on transfer: opcode<=rom_data, pc<=pc+1; next state FETCH_IMM if rom_data[7]=1, else VALID with operand<=8'h00.
REQ-018 FETCH_IMM on transfer: operand<=rom_data, pc<=pc+1, next VALID.
REQ-019 Without transfer, FETCH_OP/FETCH_IMM hold state, pc and rom_addr stable.
REQ-020 instr_valid=1 only in VALID; opcode/operand stable while instr_valid=1 and instr_ready=0.
REQ-021 VALID with instr_ready=1: instruction consumed, next state FETCH_OP next cycle (no prefetch).
REQ-022 pc increment SHALL wrap 8'hFF -> 8'h00.
REQ-023 jump_en=1 has priority in every state: pc<=jump_target, state<=FETCH_OP, any same-cycle ROM data discarded, instr_valid=0 next cycle.
REQ-024 jump_en and instr_ready both high in VALID: instruction counts as consumed, then jump applies.
REQ-025 Latency: one-byte instruction valid 1 cycle after its ack; two-byte 1 cycle after second ack; minimum 2 cycles/instruction (1-byte) with rom_ack tied high.

Reset
REQ-026 rst_n low asynchronously sets state=FETCH_OP, pc=8'h00, opcode=8'h00, operand=8'h00, instr_valid=0.
REQ-027 rom_req SHALL be 0 while rst_n low; reset mid-fetch discards partial instruction.
REQ-028 After rst_n release, first rom_req=1 with rom_addr=8'h00 in the first cycle.

Configuration
REQ-029 Macro FETCH_STALL_CNT_EN, when defined, SHALL add output stall_cnt (16 bits) counting cycles in FETCH_OP/FETCH_IMM with rom_req=1 and rom_ack=0, saturating at 16'hFFFF, reset to 0.
REQ-030 Without FETCH_STALL_CNT_EN, stall_cnt port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package cpuy_pkg SHALL hold fetch state enum, ADDR_W=8, RESET_VECTOR=8'h00, IMM_FLAG_BIT=7.
REQ-032 Sub-module cpuy_pc SHALL hold the program counter (async reset, load, increment-with-wrap).

Verification
REQ-033 ROM 8'h00=8'h05, rom_ack tied 1, instr_ready=1 -> opcode=8'h05, operand=8'h00, instr_valid one cycle, pc=8'h01.
REQ-034 ROM 8'h00=8'h83, 8'h01=8'h2A -> opcode=8'h83, operand=8'h2A, pc=8'h02.
REQ-035 rom_ack delayed 3 cycles, instr_ready low 4 cycles in VALID -> rom_addr stable, opcode/operand stable, single instruction consumed; stall_cnt=3 when FETCH_STALL_CNT_EN.
REQ-036 jump_en=1, jump_target=8'h40 coinciding with an ack in FETCH_IMM -> byte discarded, next rom_addr=8'h40, instr_valid stays 0.
REQ-037 Start at pc=8'hFF with opcode 8'h81 -> immediate fetched from 8'h00, pc=8'h01.
REQ-038 rst_n pulsed low during FETCH_IMM -> outputs zero immediately, next fetch from 8'h00.

Source files
------------

// File: rtl/cpuy_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpuy_pkg
// Purpose  : Shared types and constants for the cpuy instruction fetch unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpuy_pkg;

  // Width of the ROM byte address and program counter
  localparam int ADDR_W = 8;

  // Address the program counter returns to on reset
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 8'h00;

  // Opcode bit that marks a two-byte (opcode + immediate) instruction
  localparam int IMM_FLAG_BIT = 7;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    VALID     = 2'd2
  } fetch_state_t;

endpackage : cpuy_pkg

`default_nettype wire

// File: rtl/cpuy_pc.sv
//------------------------------------------------------------------------------
// Module   : cpuy_pc
// Purpose  : Program counter with asynchronous reset, load and wrapping
//            increment. Load has priority over increment.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpuy_pc
  import cpuy_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;

  // Counter register; the natural overflow of the adder gives FF -> 00 wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
    end else if (load) begin
      r_pc <= load_val;
    end else if (inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign pc = r_pc;

endmodule : cpuy_pc

`default_nettype wire

// File: rtl/fetch.sv
//------------------------------------------------------------------------------
// Module   : fetch
// Purpose  : Instruction fetch unit. Reads a one- or two-byte instruction from
//            ROM, presents it to the decoder with a valid/ready handshake and
//            supports jump redirection at any time.
// Options  : FETCH_STALL_CNT_EN - adds a saturating 16-bit stall_cnt output
//            counting fetch cycles where the ROM did not acknowledge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch
  import cpuy_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_req,
  output logic [7:0]  rom_addr,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic [7:0]  opcode,
  output logic [7:0]  operand,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump_en,
  input  logic [7:0]  jump_target,
  output logic [7:0]  pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  fetch_state_t r_state;
  logic [7:0]   r_opcode;
  logic [7:0]   r_operand;
  logic         r_instr_valid;
  logic         w_fetching;
  logic         w_xfer;
  logic [7:0]   w_pc;

  // rst_n is folded in so no request is visible while reset is asserted,
  // even though the reset state itself is a fetch state
  assign w_fetching = (r_state == FETCH_OP) || (r_state == FETCH_IMM);
  assign rom_req    = rst_n & w_fetching;
  assign rom_addr   = w_pc;
  assign w_xfer     = rom_req & rom_ack;

  // Program counter: jump loads, an accepted byte advances
  cpuy_pc u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (jump_en),
    .load_val (jump_target),
    .inc      (w_xfer & ~jump_en),
    .pc       (w_pc)
  );

  // Fetch sequencer with registered instruction outputs; jump overrides all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH_OP;
      r_opcode      <= 8'h00;
      r_operand     <= 8'h00;
      r_instr_valid <= 1'b0;
    end else if (jump_en) begin
      r_state       <= FETCH_OP;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH_OP: begin
          if (w_xfer) begin
            r_opcode <= rom_data;
            if (rom_data[IMM_FLAG_BIT]) begin
              r_state <= FETCH_IMM;
            end else begin
              r_operand     <= 8'h00;
              r_state       <= VALID;
              r_instr_valid <= 1'b1;
            end
          end
        end
        FETCH_IMM: begin
          if (w_xfer) begin
            r_operand     <= rom_data;
            r_state       <= VALID;
            r_instr_valid <= 1'b1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            r_state       <= FETCH_OP;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= FETCH_OP;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign opcode      = r_opcode;
  assign operand     = r_operand;
  assign instr_valid = r_instr_valid;
  assign pc          = w_pc;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of requested-but-unacknowledged fetch cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (rom_req && !rom_ack && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule : fetch

`default_nettype wire

// File: tb/tb_fetch.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch
// Purpose  : Self-checking bench for the fetch unit using a per-cycle vector
//            table plus a hand-written asynchronous reset sequence.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch;

  logic        clk;
  logic        rst_n;
  logic        rom_req;
  logic [7:0]  rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic [7:0]  opcode;
  logic [7:0]  operand;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [7:0]  jump_target;
  logic [7:0]  pc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [7:0] rom [0:255];
  int checks;
  int errors;

  typedef struct {
    logic       ack;
    logic       ready;
    logic       jmp;
    logic [7:0] tgt;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [7:0] e_op;
    logic [7:0] e_opd;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .pc          (pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ack, input logic ready, input logic jmp, input logic [7:0] tgt,
                     input logic e_req, input logic [7:0] e_addr, input logic e_valid,
                     input logic [7:0] e_op, input logic [7:0] e_opd, input logic [7:0] e_pc);
    vec_t v;
    v.ack = ack; v.ready = ready; v.jmp = jmp; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_op = e_op; v.e_opd = e_opd; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [7:0] e_addr,
                         input logic e_valid, input logic [7:0] e_op, input logic [7:0] e_opd,
                         input logic [7:0] e_pc);
    chk({tag, " rom_req"},     {15'd0, rom_req},     {15'd0, e_req});
    chk({tag, " rom_addr"},    {8'd0, rom_addr},     {8'd0, e_addr});
    chk({tag, " instr_valid"}, {15'd0, instr_valid}, {15'd0, e_valid});
    chk({tag, " opcode"},      {8'd0, opcode},       {8'd0, e_op});
    chk({tag, " operand"},     {8'd0, operand},      {8'd0, e_opd});
    chk({tag, " pc"},          {8'd0, pc},           {8'd0, e_pc});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h05;   // one-byte op; also the immediate after the wrap
    rom[8'h01] = 8'h83;
    rom[8'h02] = 8'h2A;
    rom[8'h03] = 8'h84;
    rom[8'h04] = 8'h11;
    rom[8'h05] = 8'h90;
    rom[8'h06] = 8'h77;   // dropped by the jump
    rom[8'h40] = 8'h12;
    rom[8'hFF] = 8'h81;

    //    ack rdy jmp tgt    req addr   vld op     opd    pc
    add(1, 1, 0, 8'h00,  1, 8'h00, 0, 8'h00, 8'h00, 8'h00); // 0: first fetch at 00
    add(1, 1, 0, 8'h00,  0, 8'h01, 1, 8'h05, 8'h00, 8'h01); // 1: 1-byte valid, consumed
    add(1, 1, 0, 8'h00,  1, 8'h01, 0, 8'h05, 8'h00, 8'h01); // 2: fetch 83
    add(1, 1, 0, 8'h00,  1, 8'h02, 0, 8'h83, 8'h00, 8'h02); // 3: fetch imm 2A
    add(0, 0, 0, 8'h00,  0, 8'h03, 1, 8'h83, 8'h2A, 8'h03); // 4: held, not ready
    add(0, 1, 0, 8'h00,  0, 8'h03, 1, 8'h83, 8'h2A, 8'h03); // 5: consumed
    add(0, 1, 0, 8'h00,  1, 8'h03, 0, 8'h83, 8'h2A, 8'h03); // 6: stall 1
    add(0, 1, 0, 8'h00,  1, 8'h03, 0, 8'h83, 8'h2A, 8'h03); // 7: stall 2
    add(0, 1, 0, 8'h00,  1, 8'h03, 0, 8'h83, 8'h2A, 8'h03); // 8: stall 3
    add(1, 1, 0, 8'h00,  1, 8'h03, 0, 8'h83, 8'h2A, 8'h03); // 9: ack 84
    add(1, 1, 0, 8'h00,  1, 8'h04, 0, 8'h84, 8'h2A, 8'h04); // 10: ack imm 11
    add(1, 0, 0, 8'h00,  0, 8'h05, 1, 8'h84, 8'h11, 8'h05); // 11..14: not ready
    add(1, 0, 0, 8'h00,  0, 8'h05, 1, 8'h84, 8'h11, 8'h05);
    add(1, 0, 0, 8'h00,  0, 8'h05, 1, 8'h84, 8'h11, 8'h05);
    add(1, 0, 0, 8'h00,  0, 8'h05, 1, 8'h84, 8'h11, 8'h05);
    add(1, 1, 0, 8'h00,  0, 8'h05, 1, 8'h84, 8'h11, 8'h05); // 15: consumed once
    add(1, 1, 0, 8'h00,  1, 8'h05, 0, 8'h84, 8'h11, 8'h05); // 16: fetch 90
    add(1, 1, 1, 8'h40,  1, 8'h06, 0, 8'h90, 8'h11, 8'h06); // 17: jump with imm ack
    add(1, 1, 0, 8'h00,  1, 8'h40, 0, 8'h90, 8'h11, 8'h40); // 18: fetch at target
    add(1, 1, 1, 8'hFF,  0, 8'h41, 1, 8'h12, 8'h00, 8'h41); // 19: ready+jump in VALID
    add(1, 0, 0, 8'h00,  1, 8'hFF, 0, 8'h12, 8'h00, 8'hFF); // 20: fetch 81 at FF
    add(1, 0, 0, 8'h00,  1, 8'h00, 0, 8'h81, 8'h00, 8'h00); // 21: imm from wrapped 00
    add(0, 0, 0, 8'h00,  0, 8'h01, 1, 8'h81, 8'h05, 8'h01); // 22: held
    add(0, 1, 0, 8'h00,  0, 8'h01, 1, 8'h81, 8'h05, 8'h01); // 23: consumed

    // Reset state
    rst_n = 1'b0; rom_ack = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_target = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
`ifdef FETCH_STALL_CNT_EN
    chk("reset stall_cnt", stall_cnt, 16'h0000);
`endif
    rst_n = 1'b1;

    // Table-driven cycles
    for (int i = 0; i < vecs.size(); i++) begin
      rom_ack     = vecs[i].ack;
      instr_ready = vecs[i].ready;
      jump_en     = vecs[i].jmp;
      jump_target = vecs[i].tgt;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
              vecs[i].e_op, vecs[i].e_opd, vecs[i].e_pc);
      @(negedge clk);
    end
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 16'd3);
`endif

    // Reset pulsed mid-instruction while fetching the immediate
    rom_ack = 1'b1; instr_ready = 1'b0; jump_en = 1'b0;
    @(negedge clk);               // 83 accepted -> FETCH_IMM, pc 02
    rom_ack = 1'b0;
    #1;
    chk_all("imm_pre_rst", 1'b1, 8'h02, 1'b0, 8'h83, 8'h05, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
`ifdef FETCH_STALL_CNT_EN
    chk("async_rst stall_cnt", stall_cnt, 16'h0000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rom_ack = 1'b1;
    #1;
    chk_all("post_rst", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk_all("post_rst_instr", 1'b0, 8'h01, 1'b1, 8'h05, 8'h00, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch

`default_nettype wire
